neuron_mac16: RTL and testbench

NEURON_MAC16 -- requirements
Module: neuron_mac16

---
 rtl/neuron_mac16.sv | 193 +++++++++++++++++++
 tb/tb_neuron_mac16.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac16.sv
// neuron_mac16: 16-tap fixed-point neuron.
// Accumulates x_k * w_k over a frame of 16 accepted activation beats, then adds
// the FRAC_BITS-aligned bias, shifts back to the data format and presents the
// result on a valid/ready output port.
// Optional feature macro: NEURON_MAC16_SAT_EN -- when defined the result is
// clamped to the signed DATA_WIDTH range, otherwise it wraps (low bits kept).
module neuron_mac16 #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic signed [DATA_WIDTH-1:0] w0,
    input  logic signed [DATA_WIDTH-1:0] w1,
    input  logic signed [DATA_WIDTH-1:0] w2,
    input  logic signed [DATA_WIDTH-1:0] w3,
    input  logic signed [DATA_WIDTH-1:0] w4,
    input  logic signed [DATA_WIDTH-1:0] w5,
    input  logic signed [DATA_WIDTH-1:0] w6,
    input  logic signed [DATA_WIDTH-1:0] w7,
    input  logic signed [DATA_WIDTH-1:0] w8,
    input  logic signed [DATA_WIDTH-1:0] w9,
    input  logic signed [DATA_WIDTH-1:0] w10,
    input  logic signed [DATA_WIDTH-1:0] w11,
    input  logic signed [DATA_WIDTH-1:0] w12,
    input  logic signed [DATA_WIDTH-1:0] w13,
    input  logic signed [DATA_WIDTH-1:0] w14,
    input  logic signed [DATA_WIDTH-1:0] w15,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    // Accumulator is wide enough for 16 full-scale products plus the bias.
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + 4;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_armed;
    logic [3:0]                  r_idx;
    logic signed [ACC_W-1:0]     r_acc_p0;
    logic signed [DATA_WIDTH-1:0] r_out_p1;

    logic                        w_in_ready;
    logic                        w_out_valid;
    logic                        w_accept;
    logic signed [DATA_WIDTH-1:0] w_taps [16];
    logic signed [DATA_WIDTH-1:0] w_wsel;
    logic signed [PROD_W-1:0]    w_x_ext;
    logic signed [PROD_W-1:0]    w_w_ext;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]     w_prod_ext;
    logic signed [ACC_W-1:0]     w_bias_al;
    logic signed [ACC_W-1:0]     w_sum;

    // Drop FRAC_BITS fractional bits; arithmetic shift truncates toward -inf.
    function automatic logic signed [ACC_W-1:0] f_scale(input logic signed [ACC_W-1:0] v);
        return v >>> FRAC_BITS;
    endfunction

    // Reduce the scaled sum to the output width (clamp or wrap).
    function automatic logic signed [DATA_WIDTH-1:0] f_narrow(input logic signed [ACC_W-1:0] v);
`ifdef NEURON_MAC16_SAT_EN
        logic signed [ACC_W-1:0] lim_hi;
        logic signed [ACC_W-1:0] lim_lo;
        lim_hi = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        lim_lo = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        if (v > lim_hi) begin
            return lim_hi[DATA_WIDTH-1:0];
        end else if (v < lim_lo) begin
            return lim_lo[DATA_WIDTH-1:0];
        end else begin
            return v[DATA_WIDTH-1:0];
        end
`else
        return v[DATA_WIDTH-1:0];
`endif
    endfunction

    // Tap selection: the weight is picked by the current index in the
    // accepting cycle, straight from the weight ports.
    assign w_taps[0]  = w0;
    assign w_taps[1]  = w1;
    assign w_taps[2]  = w2;
    assign w_taps[3]  = w3;
    assign w_taps[4]  = w4;
    assign w_taps[5]  = w5;
    assign w_taps[6]  = w6;
    assign w_taps[7]  = w7;
    assign w_taps[8]  = w8;
    assign w_taps[9]  = w9;
    assign w_taps[10] = w10;
    assign w_taps[11] = w11;
    assign w_taps[12] = w12;
    assign w_taps[13] = w13;
    assign w_taps[14] = w14;
    assign w_taps[15] = w15;
    assign w_wsel     = w_taps[r_idx];

    // Stage p0: multiply the accepted beat by its tap weight.
    assign w_x_ext    = PROD_W'(in_data);
    assign w_w_ext    = PROD_W'(w_wsel);
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_prod_ext = ACC_W'(w_prod);

    // Stage p1: bias alignment and final sum, consumed in FIN.
    assign w_bias_al  = ACC_W'(bias) <<< FRAC_BITS;
    assign w_sum      = r_acc_p0 + w_bias_al;

    assign w_accept   = w_in_ready & in_valid;
    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = r_out_p1;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; ready only in ACC once out of reset.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = r_armed;
                if (r_armed && in_valid && (r_idx == 4'd15)) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    // Arm flag: holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Accumulate products and step the tap index; clear on output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_p0 <= '0;
            r_idx    <= 4'd0;
        end else if (w_accept) begin
            r_acc_p0 <= r_acc_p0 + w_prod_ext;
            r_idx    <= r_idx + 4'd1;
        end else if (w_out_valid && out_ready) begin
            r_acc_p0 <= '0;
        end
    end

    // Result register: loaded once in FIN, held through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p1 <= '0;
        end else if (r_state == ST_FIN) begin
            r_out_p1 <= f_narrow(f_scale(w_sum));
        end
    end

endmodule

// File: tb/tb_neuron_mac16.sv
// Bench for neuron_mac16: frame-level reference model checked every cycle,
// plus directed frames with hand-computed results.
module tb_neuron_mac16;
    localparam int DW = 16;
    localparam int FB = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic signed [DW-1:0] bias = '0;
    logic signed [DW-1:0] w [16];
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;

    int total = 0;
    int bad = 0;
    int dut_acc = 0;

    always #5 clk = ~clk;

    neuron_mac16 #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]),
        .w4(w[4]), .w5(w[5]), .w6(w[6]), .w7(w[7]),
        .w8(w[8]), .w9(w[9]), .w10(w[10]), .w11(w[11]),
        .w12(w[12]), .w13(w[13]), .w14(w[14]), .w15(w[15]),
        .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: result of a frame from the arithmetic definition.
    function automatic logic signed [DW-1:0] neuron_result(input longint s, input logic signed [DW-1:0] b);
        longint r;
        r = (s + longint'(b) * (longint'(1) << FB)) >>> FB;
`ifdef NEURON_MAC16_SAT_EN
        if (r > 32767) return 16'sh7FFF;
        if (r < -32768) return 16'sh8000;
`endif
        return r[DW-1:0];
    endfunction

    // Behavioural model: beats collected, one-cycle finish, result held.
    bit                   m_armed = 0;
    bit                   m_fin = 0;
    bit                   m_have = 0;
    int                   m_n = 0;
    longint               m_sum = 0;
    logic signed [DW-1:0] m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_armed = 0; m_fin = 0; m_have = 0; m_n = 0; m_sum = 0; m_out = '0;
        end else begin
            if (m_have) begin
                if (out_ready) m_have = 0;
            end else if (m_fin) begin
                m_out = neuron_result(m_sum, bias);
                m_sum = 0;
                m_fin = 0;
                m_have = 1;
            end else if (m_armed && in_valid) begin
                m_sum += longint'(in_data) * longint'(w[m_n]);
                m_n++;
                if (m_n == 16) begin
                    m_n = 0;
                    m_fin = 1;
                end
            end
            m_armed = 1;
        end
    end

    // Count beats the DUT actually accepted.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) dut_acc++;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", {15'd0, in_ready}, {15'd0, m_armed && !m_fin && !m_have});
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_have});
        chk("out_data", out_data, m_out);
    end

    task automatic set_weights(input logic signed [DW-1:0] v);
        for (int i = 0; i < 16; i++) w[i] = v;
    endtask

    task automatic rand_weights();
        for (int i = 0; i < 16; i++) w[i] = 16'($urandom);
    endtask

    // Offer one beat after 'gap' idle cycles; return once accepted.
    task automatic send(input logic signed [DW-1:0] x, input int gap);
        int t;
        logic got;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = x;
        t = 0;
        forever begin
            got = in_ready;
            @(negedge clk);
            if (got) break;
            t++;
            if (t > 50) begin
                chk("send_timeout", 16'd1, 16'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Called right after the 16th accept: FIN cycle, then OUT with result.
    task automatic finish_frame(input string nm, input logic [DW-1:0] exp);
        chk({nm, "_fin_valid"}, {15'd0, out_valid}, 16'd0);
        chk({nm, "_fin_ready"}, {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        chk({nm, "_lat_valid"}, {15'd0, out_valid}, 16'd1);
        chk({nm, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_ack"}, {15'd0, out_valid}, 16'd0);
    endtask

    task automatic drain(input int dly);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("drain_timeout", 16'd0, 16'd1);
        repeat (dly) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_data", out_data, 16'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int a0;
        logic [DW-1:0] hold;
        logic signed [DW-1:0] x;
        set_weights('0);
        repeat (3) @(negedge clk);
        chk("reset_ready", {15'd0, in_ready}, 16'd0);
        chk("reset_valid", {15'd0, out_valid}, 16'd0);
        chk("reset_data", out_data, 16'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {15'd0, in_ready}, 16'd1);

        // Unit weights, back-to-back beats.
        set_weights(16'sh0100);
        bias = 16'sh0080;
        for (int i = 0; i < 16; i++) send(16'sh0100, 0);
        finish_frame("unit", 16'h1080);

        // Negative weights, in_valid toggling.
        set_weights(16'shFF00);
        bias = '0;
        a0 = dut_acc;
        for (int i = 0; i < 16; i++) send(16'sh0180, 1);
        finish_frame("toggle", 16'hE800);
        chk("toggle_beats", 16'(dut_acc - a0), 16'd16);

        // Full-scale products.
        set_weights(16'sh7FFF);
`ifdef NEURON_MAC16_SAT_EN
        for (int i = 0; i < 16; i++) send(16'sh7FFF, 0);
        finish_frame("fullscale", 16'h7FFF);
`else
        for (int i = 0; i < 16; i++) send(16'sh7FFF, 0);
        finish_frame("fullscale", 16'hF000);
`endif

        // Backpressure on the output with beats offered meanwhile.
        rand_weights();
        bias = 16'($urandom);
        for (int i = 0; i < 16; i++) send(16'($urandom), 0);
        @(negedge clk);
        chk("bp_valid", {15'd0, out_valid}, 16'd1);
        hold = out_data;
        a0 = dut_acc;
        in_valid = 1'b1;
        in_data = 16'sh0123;
        repeat (5) begin
            @(negedge clk);
            chk("bp_stable", out_data, hold);
            chk("bp_ready", {15'd0, in_ready}, 16'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_no_accept_on_ack", 16'(dut_acc - a0), 16'd0);
        chk("bp_ready_after_ack", {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept_next", 16'(dut_acc - a0), 16'd1);
        for (int i = 0; i < 15; i++) send(16'($urandom), 0);
        drain(0);

        // Reset mid-frame discards the partial sum.
        rand_weights();
        for (int i = 0; i < 7; i++) send(16'($urandom), 0);
        pulse_reset();
        bias = 16'shFF9A;
        for (int i = 0; i < 16; i++) send(16'sh0000, 0);
        finish_frame("abort", 16'hFF9A);

        // Reset while a result is pending drops it.
        for (int i = 0; i < 16; i++) send(16'sh0200, 0);
        @(negedge clk);
        chk("pend_valid", {15'd0, out_valid}, 16'd1);
        pulse_reset();
        chk("pend_dropped", {15'd0, out_valid}, 16'd0);

        // Random frames, random gaps and output stalls.
        for (int f = 0; f < 24; f++) begin
            rand_weights();
            bias = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                if (f % 2 == 0) x = 16'($urandom);
                else x = 16'($urandom_range(0, 1023)) - 16'sd512;
                send(x, $urandom_range(0, 2));
            end
            drain($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
